alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that sits in front of the existing 32-bit combinational ALU and drives the ALU's operand and function inputs. Single-cycle ops (ADD/SUB/AND/OR/NOR/XOR) pass straight through in one ALU pass. Multi-bit shifts (SL/SRA/SRL by datab[4:0]) are built by iterating the ALU's 1-bit shift, one pass per cycle. The requester side uses valid/ready handshakes on both the command and the result.

Parameters:
DATA_W, 32, operand/result width; fixed to the ALU width, no other value supported
SHAMT_W, 5, shift-amount width taken from datab[SHAMT_W-1:0]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  4  function code, same encoding as the ALU: ADD 0000, SUB 0010, AND 0100, OR 0101, NOR 0110, XOR 0111, SL 1000, SRA 1001, SRL 1010
cmd_a  in  32  operand A
cmd_b  in  32  operand B; for shifts, bits [4:0] give the amount
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_result  out  32  result
rsp_err  out  1  command had an illegal op code
alu_dataa  out  32  to ALU dataa
alu_datab  out  32  to ALU datab
alu_function  out  4  to ALU Function
alu_result  in  32  from ALU result
busy  out  1  high in EXEC or DONE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- State machine: IDLE, EXEC, DONE, with registers acc[31:0], b_reg[31:0], op_reg[3:0], cnt[4:0], err_reg.
- Reset (rst_n low, asynchronous): state=IDLE; acc, b_reg, op_reg, cnt all 0; err_reg=0. Outputs: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, busy=0, alu_*=0.
- Reset mid-operation: any in-flight command is dropped; no response is produced.
- cmd_ready=1 only in IDLE. A command is accepted on a rising edge with cmd_valid & cmd_ready. On accept: acc<=cmd_a, b_reg<=cmd_b, op_reg<=cmd_op.
- Accept transitions:
  - Legal non-shift op -> EXEC.
  - Shift op with cmd_b[4:0]!=0 -> cnt<=cmd_b[4:0], EXEC.
  - Shift op with cmd_b[4:0]==0 -> DONE directly, acc=cmd_a.
  - Illegal op (0001, 0011, 1011-1111) -> DONE with acc<=0, err_reg<=1. The ALU is never exercised for an illegal op.
- ALU drive:
  - In EXEC: alu_dataa=acc, alu_datab=b_reg, alu_function=op_reg.
  - Outside EXEC: alu_* = 0, alu_function=ADD. The ALU's x default is never selected.
- EXEC, non-shift: acc<=alu_result, then go to DONE.
- EXEC, shift: acc<=alu_result and cnt<=cnt-1. Go to DONE when cnt==1, otherwise stay in EXEC.
- Arithmetic and width rules:
  - The amount uses b[4:0] only, so the maximum is 31 passes. Upper bits of b are ignored for shifts.
  - ADD/SUB wrap modulo 2^32, with no carry or overflow output.
- DONE: rsp_valid=1, rsp_result=acc, rsp_err=err_reg. These hold stable until rsp_ready. When rsp_valid & rsp_ready: go to IDLE and clear err_reg. cmd_ready rises the following cycle; there is no same-cycle re-accept.
- Latency, with accept at edge T (counted as rsp_valid high after edge T+k):
  - Non-shift: k=2.
  - Shift by N>=1: k=N+1.
  - Shift by 0 or illegal op: k=1.
- Backpressure: rsp_ready low in DONE holds indefinitely; cmd_valid is ignored while cmd_ready=0.
- rsp_ready outside DONE has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit op-code localparams (ADD…SRL);
  - the state encoding (IDLE=2'd0, EXEC=2'd1, DONE=2'd2);
  - an is_shift/is_legal decode function, also reused by the ALU and decode stages.
- The ALU stays external and connects through the alu_* ports, so it can be shared or muxed later. No sub-module is needed; the counter and FSM live in one module.

Test Plan:
- Reset: pulse rst_n low mid-shift (cnt=7) -> immediately cmd_ready=1, rsp_valid=0, busy=0, alu_function=0000; no response ever appears for the aborted command.
- Pass-through op: ADD a=32'hFFFF_FFFF, b=1 -> rsp_valid at T+2, result=0, err=0. SUB 5-7 -> 32'hFFFF_FFFE. NOR 0,0 -> 32'hFFFF_FFFF.
- Shifts:
  - SRA a=32'h8000_0000, b=31 -> 31 EXEC cycles, result 32'hFFFF_FFFF at T+32.
  - SRL same operands -> 32'h0000_0001.
  - SL a=1, b=32'hFFFF_FFE4 (amount 4) -> 32'h10 at T+5.
- Zero-amount shift: SL a=32'h1234_5678, b=0 -> rsp_valid at T+1, result=32'h1234_5678, alu_function never 1000.
- Illegal op 0011 -> rsp_valid at T+1, rsp_result=0, rsp_err=1; next legal command returns rsp_err=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> result stable, cmd_ready=0 throughout; after the rsp_ready pulse, cmd_ready=1 the next cycle and the new command is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, sequencer state encoding and op decode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SL  = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SL) || (op == OP_SRA) || (op == OP_SRL);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_XOR: legal = 1'b1;
            default:                                       legal = is_shift(op);
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer in front of the external 32-bit ALU; multi-bit shifts are
// built from repeated 1-bit ALU shift passes.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_dataa,
    output logic [DATA_W-1:0] alu_datab,
    output logic [3:0]        alu_function,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    state_t               state;
    state_t               next_state;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    b_reg;
    logic [3:0]           op_reg;
    logic [SHAMT_W-1:0]   cnt;
    logic                 err_reg;

    logic                 cmd_legal;
    logic                 cmd_shift;
    logic                 cmd_zero_amt;

    assign cmd_legal    = is_legal(cmd_op);
    assign cmd_shift    = is_shift(cmd_op);
    assign cmd_zero_amt = (cmd_b[SHAMT_W-1:0] == '0);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_legal || (cmd_shift && cmd_zero_amt))
                        next_state = DONE;
                    else
                        next_state = EXEC;
                end
            end
            EXEC: begin
                if (!is_shift(op_reg) || (cnt == SHAMT_W'(1)))
                    next_state = DONE;
            end
            DONE: begin
                if (rsp_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outside EXEC the ALU is parked on ADD with zero operands so its undefined
    // default function is never selected.
    always_comb begin
        cmd_ready    = (state == IDLE);
        rsp_valid    = (state == DONE);
        rsp_result   = '0;
        rsp_err      = 1'b0;
        busy         = (state == EXEC) || (state == DONE);
        alu_dataa    = '0;
        alu_datab    = '0;
        alu_function = OP_ADD;
        if (state == EXEC) begin
            alu_dataa    = acc;
            alu_datab    = b_reg;
            alu_function = op_reg;
        end
        if (state == DONE) begin
            rsp_result = acc;
            rsp_err    = err_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            cnt     <= '0;
            err_reg <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        acc     <= cmd_legal ? cmd_a : '0;
                        b_reg   <= cmd_b;
                        op_reg  <= cmd_op;
                        err_reg <= !cmd_legal;
                        if (cmd_shift)
                            cnt <= cmd_b[SHAMT_W-1:0];
                    end
                end
                EXEC: begin
                    acc <= alu_result;
                    if (is_shift(op_reg))
                        cnt <= cnt - SHAMT_W'(1);
                end
                DONE: begin
                    if (rsp_ready)
                        err_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural model of the external ALU.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'd0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [31:0] alu_dataa;
    logic [31:0] alu_datab;
    logic [3:0]  alu_function;
    logic [31:0] alu_result;
    logic        busy;

    int cmp_count = 0;
    int fail_count = 0;
    bit alu_touched = 1'b0;

    typedef struct {
        logic [31:0] result;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        err;
        int          lat;
        bit          no_alu;
    } vec_t;

    exp_t exp_q[$];

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_dataa(alu_dataa), .alu_datab(alu_datab),
        .alu_function(alu_function), .alu_result(alu_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external ALU (shifts are 1-bit per pass).
    always_comb begin
        case (alu_function)
            4'b0000: alu_result = alu_dataa + alu_datab;
            4'b0010: alu_result = alu_dataa - alu_datab;
            4'b0100: alu_result = alu_dataa & alu_datab;
            4'b0101: alu_result = alu_dataa | alu_datab;
            4'b0110: alu_result = ~(alu_dataa | alu_datab);
            4'b0111: alu_result = alu_dataa ^ alu_datab;
            4'b1000: alu_result = alu_dataa << 1;
            4'b1001: alu_result = $signed(alu_dataa) >>> 1;
            4'b1010: alu_result = alu_dataa >> 1;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk)
        if (alu_function != 4'b0000 || alu_dataa != 0 || alu_datab != 0)
            alu_touched <= 1'b1;

    function automatic bit refLegal(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return ~(a | b);
            4'b0111: return a ^ b;
            4'b1000: return a << b[4:0];
            4'b1001: return $signed(a) >>> b[4:0];
            4'b1010: return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    function automatic int refLat(input logic [3:0] op, input logic [31:0] b);
        if (!refLegal(op)) return 1;
        if (op[3]) return (b[4:0] == 0) ? 1 : int'(b[4:0]) + 1;
        return 2;
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one command, waits for acceptance and records the expected response.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_res, input logic exp_err, input int exp_lat);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) compareVal("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        alu_touched = 1'b0;
        e.result = exp_res; e.err = exp_err; e.lat = exp_lat;
        exp_q.push_back(e);
    endtask

    // Latency counts rising edges from the accept edge (counted as 1) until rsp_valid.
    task automatic checkOutput(input string tag, input bit no_alu);
        exp_t e;
        int lat = 1;
        e = exp_q.pop_front();
        forever begin
            @(negedge clk);
            if (rsp_valid || lat > 100) break;
            lat++;
        end
        if (!rsp_valid) begin
            compareVal({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        compareVal({tag, "_result"}, rsp_result, e.result);
        compareVal({tag, "_err"}, 32'(rsp_err), 32'(e.err));
        compareVal({tag, "_latency"}, lat, e.lat);
        if (no_alu) compareVal({tag, "_alu_idle"}, 32'(alu_touched), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        compareVal({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    vec_t vecs[14];

    initial begin
        bit stable;
        bit seen;
        int waited;
        exp_t e;

        vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 2,  1'b0};
        vecs[1]  = '{OP_SUB, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 2,  1'b0};
        vecs[2]  = '{OP_NOR, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0, 2,  1'b0};
        vecs[3]  = '{OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 2,  1'b0};
        vecs[4]  = '{OP_OR,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0, 2,  1'b0};
        vecs[5]  = '{OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 2,  1'b0};
        vecs[6]  = '{OP_SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32, 1'b0};
        vecs[7]  = '{OP_SRL, 32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0, 32, 1'b0};
        vecs[8]  = '{OP_SL,  32'h1,         32'hFFFF_FFE4, 32'h10,        1'b0, 5,  1'b0};
        vecs[9]  = '{OP_SL,  32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1,  1'b1};
        vecs[10] = '{4'b0011, 32'h1234,     32'h5,         32'h0,         1'b1, 1,  1'b1};
        vecs[11] = '{OP_ADD, 32'h2,         32'h3,         32'h5,         1'b0, 2,  1'b0};
        vecs[12] = '{4'b1111, 32'h5,        32'h5,         32'h0,         1'b1, 1,  1'b1};
        vecs[13] = '{OP_SRA, 32'hF000_0000, 32'h0000_0024, 32'hFF00_0000, 1'b0, 5,  1'b0};

        repeat (3) @(negedge clk);
        compareVal("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        compareVal("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        compareVal("reset_busy", 32'(busy), 32'd0);
        compareVal("reset_rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].result, vecs[i].err, vecs[i].lat);
            checkOutput($sformatf("vec%0d", i), vecs[i].no_alu);
        end

        for (int i = 0; i < 6; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            applyStimulus(op, a, b, refResult(op, a, b), !refLegal(op), refLat(op, b));
            checkOutput($sformatf("rand%0d", i), !refLegal(op));
        end

        // Backpressure: hold the result while a second command waits.
        applyStimulus(OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0, 2);
        e = exp_q.pop_front();
        waited = 0;
        while (!rsp_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        compareVal("bp_first_result", rsp_result, e.result);
        cmd_op = OP_XOR; cmd_a = 32'hFF; cmd_b = 32'h0F; cmd_valid = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_result !== 32'd30 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) stable = 1'b0;
        end
        compareVal("bp_hold", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        compareVal("bp_ready_next", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        alu_touched = 1'b0;
        e.result = 32'hF0; e.err = 1'b0; e.lat = 2;
        exp_q.push_back(e);
        checkOutput("bp_second", 1'b0);

        // Asynchronous reset in the middle of a 20-step shift (cnt at 7).
        applyStimulus(OP_SRL, 32'hFFFF_FFFF, 32'd20, 32'h0, 1'b0, 21);
        exp_q.delete();
        repeat (13) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compareVal("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
        compareVal("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        compareVal("midreset_busy", 32'(busy), 32'd0);
        compareVal("midreset_alu_function", 32'(alu_function), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        compareVal("midreset_no_response", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
